// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART TX arbiter: FSM state encoding, byte width and
// the round-robin pointer wrap helper.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above the pointer (with
// wrap), or only the owner while a lock is held.
module uart_tx_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             lock_i,
  input  logic [IDX_W-1:0] owner_i,
  output logic [N-1:0]     win_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    win_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (lock_i) begin
      if (req_i[owner_i]) begin
        win_o[owner_i] = 1'b1;
        idx_o          = owner_i;
        any_o          = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = int'(ptr_i) + k;
        if (cand >= N) cand = cand - N;
        cand_idx = IDX_W'(cand);
        if (!any_o && req_i[cand_idx]) begin
          win_o[cand_idx] = 1'b1;
          idx_o           = cand_idx;
          any_o           = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources,
// keeping packets contiguous and guarding against a transmitter that never starts.
//
// state        | meaning
// IDLE         | pick a requester (owner only while locked), accept when tx idle
// ISSUE        | one-cycle tx_start_o, watchdog cleared
// WAIT_BUSY    | wait for tx_busy_i to rise, watchdog running
// WAIT_DONE    | wait for tx_busy_i to fall, then release or keep the lock
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [8*N_REQ-1:0]    req_data_i,
  input  logic [N_REQ-1:0]      req_last_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic [BYTE_W-1:0]     tx_data_o,
  output logic                  tx_start_o,
  input  logic                  tx_busy_i,
  output logic [N_REQ-1:0]      grant_o,
  output logic                  err_timeout_o,
  output logic                  active_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              last_q, last_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  win;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic              ready_en;
  logic              xfer;
  logic [BYTE_W-1:0] byte_sel;
  logic              last_sel;
  logic [IDX_W-1:0]  owner_inc;

  uart_tx_arbiter_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .lock_i  (lock_q),
    .owner_i (owner_q),
    .win_o   (win),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  // Ready is held off during reset so a valid source cannot see a stray handshake.
  assign ready_en    = rst_i && (state_q == ST_IDLE) && !tx_busy_i;
  assign req_ready_o = ready_en ? win : '0;
  assign xfer        = ready_en && win_any;
  assign owner_inc   = IDX_W'(wrap_inc(int'(owner_q), N_REQ));

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i == int'(win_idx)) byte_sel = req_data_i[i*BYTE_W +: BYTE_W];
    end
    last_sel = req_last_i[win_idx];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    wdog_d  = wdog_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          data_d  = byte_sel;
          grant_d = win;
          owner_d = win_idx;
          lock_d  = !last_sel;
          last_d  = last_sel;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (wdog_q == WD_W'(ACK_TIMEOUT - 2)) begin
          // wdog_q lags tx_start_o by a cycle; firing here lands err exactly
          // ACK_TIMEOUT cycles after the start pulse.
          err_d   = 1'b1;
          lock_d  = 1'b0;
          grant_d = '0;
          ptr_d   = owner_inc;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_d = ST_IDLE;
          if (last_q) begin
            lock_d  = 1'b0;
            grant_d = '0;
            ptr_d   = owner_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
      grant_q <= '0;
      data_q  <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign tx_data_o     = data_q;
  assign tx_start_o    = (state_q == ST_ISSUE);
  assign grant_o       = grant_q;
  assign err_timeout_o = err_q;
  assign active_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets per requester, expected
// {owner, byte} order queued by hand, checked at every tx_start_o.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_busy;
  logic [3:0]  grant_o;
  logic        err_timeout_o;
  logic        active_o;

  logic        model_busy;
  logic        busy_force;
  bit          model_en;

  assign tx_busy = model_busy | busy_force;

  uart_tx_arbiter #(
    .N_REQ       (4),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_last_i    (req_last),
    .req_ready_o   (req_ready_o),
    .tx_data_o     (tx_data_o),
    .tx_start_o    (tx_start_o),
    .tx_busy_i     (tx_busy),
    .grant_o       (grant_o),
    .err_timeout_o (err_timeout_o),
    .active_o      (active_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks;
  int          n_pass;
  int          start_cnt;
  int          err_cnt;

  logic [8:0]  src_mem [4][16];
  int          wr_p [4];
  int          rd_p [4];
  int          ready_cycles [4];
  logic [3:0]  accepted;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic last);
    src_mem[i][wr_p[i] % 16] = {last, d};
    wr_p[i]++;
  endtask

  task automatic expect_tx(input logic [1:0] i, input logic [7:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic bit sources_empty();
    for (int i = 0; i < 4; i++) if (rd_p[i] < wr_p[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      done = (exp_q.size() == 0) && sources_empty() && !active_o && !tx_busy;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requester sources: present queue heads, pop what the DUT accepted.
  initial begin
    logic [8:0] ent;
    for (int i = 0; i < 4; i++) begin
      rd_p[i]         = 0;
      ready_cycles[i] = 0;
    end
    accepted  = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (accepted[i]) rd_p[i]++;
      for (int i = 0; i < 4; i++) begin
        if (rd_p[i] < wr_p[i]) begin
          ent               = src_mem[i][rd_p[i] % 16];
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = ent[7:0];
          req_last[i]       = ent[8];
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
      #1;
      accepted = req_ready_o & req_valid;
      for (int i = 0; i < 4; i++) if (req_ready_o[i]) ready_cycles[i]++;
    end
  end

  // Transmitter model: busy one cycle after start, for 10 cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start_o && model_en) begin
        @(negedge clk);
        model_busy = 1'b1;
        repeat (10) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // Monitor: every start pulse must match the next expected frame.
  initial begin
    exp_t       e;
    logic [3:0] g;
    start_cnt = 0;
    err_cnt   = 0;
    forever begin
      @(negedge clk);
      if (err_timeout_o) err_cnt++;
      if (tx_start_o) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data_o), 32'(e.data));
          g = 4'b0001 << e.idx;
          check("grant_at_start", 32'(grant_o), 32'(g));
        end
      end
    end
  end

  initial begin
    int cyc;
    int k;
    int s0;
    int e0;
    int r0;
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    busy_force = 1'b0;
    model_en   = 1'b1;
    for (int i = 0; i < 4; i++) wr_p[i] = 0;

    // Reset state
    #2;
    check("rst_active", 32'(active_o), 32'd0);
    check("rst_start", 32'(tx_start_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_data", 32'(tx_data_o), 32'd0);
    check("rst_err", 32'(err_timeout_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready_o), 32'd0);

    // Single byte from requester 0
    s0 = start_cnt;
    r0 = ready_cycles[0];
    push(0, 8'h55, 1'b1);
    expect_tx(2'd0, 8'h55);
    wait_drain("single_drain");
    check("single_ready_cycles", 32'(ready_cycles[0] - r0), 32'd1);
    check("single_starts", 32'(start_cnt - s0), 32'd1);
    check("single_grant_clr", 32'(grant_o), 32'd0);

    // Pointer now 1: requester 1 beats requester 0
    push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    expect_tx(2'd1, 8'h11);
    expect_tx(2'd0, 8'h10);
    wait_drain("ptr_drain");

    // Contention fairness from pointer 0
    do_reset();
    s0 = start_cnt;
    push(0, 8'hC0, 1'b1);
    push(0, 8'hC4, 1'b1);
    push(1, 8'hC1, 1'b1);
    push(2, 8'hC2, 1'b1);
    push(3, 8'hC3, 1'b1);
    expect_tx(2'd0, 8'hC0);
    expect_tx(2'd1, 8'hC1);
    expect_tx(2'd2, 8'hC2);
    expect_tx(2'd3, 8'hC3);
    expect_tx(2'd0, 8'hC4);
    wait_drain("rr_drain");
    check("rr_starts", 32'(start_cnt - s0), 32'd5);

    // Packet lock keeps A1,A2 together ahead of B0
    do_reset();
    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b1);
    push(1, 8'hB0, 1'b1);
    expect_tx(2'd0, 8'hA1);
    expect_tx(2'd0, 8'hA2);
    expect_tx(2'd1, 8'hB0);
    wait_drain("lock_drain");

    // Watchdog: no busy for the first frame, lock dropped, next requester served
    do_reset();
    model_en = 1'b0;
    e0 = err_cnt;
    push(0, 8'hE0, 1'b0);
    push(1, 8'hF1, 1'b1);
    push(0, 8'hE1, 1'b1);
    expect_tx(2'd0, 8'hE0);
    expect_tx(2'd1, 8'hF1);
    expect_tx(2'd0, 8'hE1);
    cyc = 0;
    while (!tx_start_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("wd_start_seen", 32'(tx_start_o), 32'd1);
    k = 0;
    while (!err_timeout_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("wd_delay", 32'(k), 32'd16);
    check("wd_grant_clr", 32'(grant_o), 32'd0);
    check("wd_idle", 32'(active_o), 32'd0);
    model_en = 1'b1;
    @(negedge clk);
    check("wd_pulse_width", 32'(err_timeout_o), 32'd0);
    wait_drain("wd_drain");
    check("wd_err_count", 32'(err_cnt - e0), 32'd1);

    // Busy at accept blocks ready until busy falls
    do_reset();
    busy_force = 1'b1;
    r0 = ready_cycles[1];
    push(1, 8'hB5, 1'b1);
    expect_tx(2'd1, 8'hB5);
    repeat (6) @(negedge clk);
    check("busy_no_ready", 32'(ready_cycles[1] - r0), 32'd0);
    check("busy_idle", 32'(active_o), 32'd0);
    busy_force = 1'b0;
    wait_drain("busy_drain");
    check("busy_ready_cycles", 32'(ready_cycles[1] - r0), 32'd1);

    // Async reset during WAIT_DONE, then requester 0 has priority
    push(2, 8'hD2, 1'b1);
    expect_tx(2'd2, 8'hD2);
    cyc = 0;
    while (!model_busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ar_busy_seen", 32'(model_busy), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_active", 32'(active_o), 32'd0);
    check("ar_grant", 32'(grant_o), 32'd0);
    check("ar_start", 32'(tx_start_o), 32'd0);
    check("ar_data", 32'(tx_data_o), 32'd0);
    check("ar_err", 32'(err_timeout_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(3, 8'h93, 1'b1);
    push(0, 8'h90, 1'b1);
    expect_tx(2'd0, 8'h90);
    expect_tx(2'd3, 8'h93);
    wait_drain("ar_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
